// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares the single uart transmit stream among
// several byte-stream requesters. One packet per grant; a grant ends on
// tlast, after MAX_BURST beats, or after an idle timeout. A one-entry
// registered output stage isolates the uart ready from the requesters.
module uart_tx_arbiter #(
    parameter int NUM_PORTS    = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic [$clog2(NUM_PORTS)-1:0]    m_axis_tid,
    output logic                            grant_valid,
    output logic [$clog2(NUM_PORTS)-1:0]    grant_id
);

    localparam int ID_W   = $clog2(NUM_PORTS);
    localparam int IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

    // Port 0 gets first priority out of reset because the scan starts at rr_ptr+1.
    localparam logic [ID_W-1:0]   LAST_PORT  = ID_W'(NUM_PORTS - 1);
    localparam logic [7:0]        BURST_LAST = 8'(MAX_BURST - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [7:0]          beat_cnt;
    logic [IDLE_W-1:0]   idle_cnt;

    logic                  out_ready;
    logic                  granted_valid;
    logic                  granted_last;
    logic [DATA_WIDTH-1:0] granted_data;
    logic                  beat_accept;
    logic                  burst_done;
    logic                  idle_tick;
    logic                  timeout;
    logic                  pick_found;
    logic [ID_W-1:0]       pick_id;
    int                    pick_idx;

    // The output register can take a new beat when empty or draining this cycle.
    assign out_ready = !m_axis_tvalid || m_axis_tready;

    // Select the granted requester's data, valid and last.
    always_comb begin
        granted_data  = '0;
        granted_valid = 1'b0;
        granted_last  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_id == ID_W'(i)) begin
                granted_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                granted_valid = s_axis_tvalid[i];
                granted_last  = s_axis_tlast[i];
            end
        end
    end

    // Only the granted port sees ready, and only while a grant is active.
    always_comb begin
        s_axis_tready = '0;
        if (rst_n && (state == XFER)) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (grant_id == ID_W'(i)) begin
                    s_axis_tready[i] = out_ready;
                end
            end
        end
    end

    // Round-robin pick: first valid port scanning upward from rr_ptr+1.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        pick_idx   = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            pick_idx = (int'(rr_ptr) + k) % NUM_PORTS;
            if (!pick_found && s_axis_tvalid[pick_idx]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(pick_idx);
            end
        end
    end

    // Idle cycles only count when the output could have taken a beat.
    assign beat_accept = (state == XFER) && granted_valid && out_ready;
    assign burst_done  = (beat_cnt == BURST_LAST);
    assign idle_tick   = (state == XFER) && !granted_valid && out_ready;
    assign timeout     = (IDLE_TIMEOUT != 0) && idle_tick && (idle_cnt == IDLE_LAST);

    // Grant FSM: a beat always takes precedence over a coincident timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= LAST_PORT;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            beat_cnt    <= '0;
            idle_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id    <= pick_id;
                        grant_valid <= 1'b1;
                        beat_cnt    <= '0;
                        idle_cnt    <= '0;
                        state       <= XFER;
                    end
                end
                XFER: begin
                    if (beat_accept) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        idle_cnt <= '0;
                        if (granted_last || burst_done) begin
                            state       <= IDLE;
                            grant_valid <= 1'b0;
                            rr_ptr      <= grant_id;
                        end
                    end else if (timeout) begin
                        state       <= IDLE;
                        grant_valid <= 1'b0;
                        rr_ptr      <= grant_id;
                    end else if (idle_tick) begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

    // Output stage: load on accept, otherwise drain when the uart takes the beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tid    <= '0;
        end else if (beat_accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= granted_data;
            m_axis_tlast  <= granted_last;
            m_axis_tid    <= grant_id;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-port byte sources, an output
// monitor, and hand-written expected beat sequences.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rstN;
    logic [31:0] sTdata;
    logic [3:0]  sTvalid;
    logic [3:0]  sTlast;
    logic [3:0]  sTready;
    logic [7:0]  mTdata;
    logic        mTvalid;
    logic        mTready;
    logic        mTlast;
    logic [1:0]  mTid;
    logic        grantValid;
    logic [1:0]  grantId;

    logic [31:0] bTdata;
    logic [3:0]  bTvalid;
    logic [3:0]  bTlast;
    logic [3:0]  bTready;
    logic [7:0]  bMtdata;
    logic        bMtvalid;
    logic        bMtready;
    logic        bMtlast;
    logic [1:0]  bMtid;
    logic        bGrantValid;
    logic [1:0]  bGrantId;

    logic [7:0]  srcData [4][64];
    logic        srcLast [4][64];
    int          srcHead [4];
    int          srcTail [4];

    logic [7:0]  obsData [64];
    logic        obsLast [64];
    logic [1:0]  obsTid  [64];
    int          obsCount;
    int          expIdx;
    int          accLog  [64];
    int          accCount;

    int          vecCount;
    int          missCount;

    uart_tx_arbiter #(
        .NUM_PORTS(4), .DATA_WIDTH(8), .MAX_BURST(16), .IDLE_TIMEOUT(8)
    ) dut (
        .clk(clk), .rst_n(rstN),
        .s_axis_tdata(sTdata), .s_axis_tvalid(sTvalid), .s_axis_tlast(sTlast),
        .s_axis_tready(sTready),
        .m_axis_tdata(mTdata), .m_axis_tvalid(mTvalid), .m_axis_tready(mTready),
        .m_axis_tlast(mTlast), .m_axis_tid(mTid),
        .grant_valid(grantValid), .grant_id(grantId)
    );

    uart_tx_arbiter #(
        .NUM_PORTS(4), .DATA_WIDTH(8), .MAX_BURST(16), .IDLE_TIMEOUT(0)
    ) dutNoTimeout (
        .clk(clk), .rst_n(rstN),
        .s_axis_tdata(bTdata), .s_axis_tvalid(bTvalid), .s_axis_tlast(bTlast),
        .s_axis_tready(bTready),
        .m_axis_tdata(bMtdata), .m_axis_tvalid(bMtvalid), .m_axis_tready(bMtready),
        .m_axis_tlast(bMtlast), .m_axis_tid(bMtid),
        .grant_valid(bGrantValid), .grant_id(bGrantId)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it when it disagrees.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present each source's head byte on its input lane.
    task automatic driveInputs();
        for (int p = 0; p < 4; p++) begin
            if (srcHead[p] < srcTail[p]) begin
                sTvalid[p]        = 1'b1;
                sTdata[p*8 +: 8]  = srcData[p][srcHead[p]];
                sTlast[p]         = srcLast[p][srcHead[p]];
            end else begin
                sTvalid[p]        = 1'b0;
                sTdata[p*8 +: 8]  = 8'h00;
                sTlast[p]         = 1'b0;
            end
        end
    endtask

    // Queue one byte on a source.
    task automatic pushByte(input int p, input logic [7:0] d, input logic l);
        srcData[p][srcTail[p]] = d;
        srcLast[p][srcTail[p]] = l;
        srcTail[p]++;
    endtask

    // One clock: sample handshakes at the falling edge, then pop and redrive after the rising edge.
    task automatic applyStimulus();
        logic [3:0] acc;
        int         first;
        @(negedge clk);
        acc   = sTvalid & sTready;
        first = -1;
        for (int p = 3; p >= 0; p--) if (acc[p]) first = p;
        if (accCount < 64) begin
            accLog[accCount] = first;
            accCount++;
        end
        if (rstN && mTvalid && mTready && obsCount < 64) begin
            obsData[obsCount] = mTdata;
            obsLast[obsCount] = mTlast;
            obsTid[obsCount]  = mTid;
            obsCount++;
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++) if (acc[p]) srcHead[p]++;
        driveInputs();
    endtask

    // Run cycles until n output beats are seen or the budget expires.
    task automatic waitOutputs(input int n, input int budget);
        int c;
        c = 0;
        while (obsCount < n && c < budget) begin
            applyStimulus();
            c++;
        end
        checkOutput("beat_count", 32'(obsCount), 32'(n));
    endtask

    // Compare the next observed output beat against {tid, last, data}.
    task automatic expectBeat(input string tag, input logic [7:0] d, input logic l, input logic [1:0] t);
        if (expIdx < 64) begin
            checkOutput(tag, 32'({obsTid[expIdx], obsLast[expIdx], obsData[expIdx]}), 32'({t, l, d}));
        end
        expIdx++;
    endtask

    // Start a new observation window.
    task automatic clearObs();
        obsCount = 0;
        expIdx   = 0;
        accCount = 0;
    endtask

    // Hold reset for two cycles and check every output's reset value.
    task automatic resetDut();
        rstN = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("rst_m_tvalid", 32'(mTvalid), 32'd0);
        checkOutput("rst_m_tdata", 32'(mTdata), 32'd0);
        checkOutput("rst_m_tlast", 32'(mTlast), 32'd0);
        checkOutput("rst_m_tid", 32'(mTid), 32'd0);
        checkOutput("rst_grant_valid", 32'(grantValid), 32'd0);
        checkOutput("rst_grant_id", 32'(grantId), 32'd0);
        rstN = 1'b1;
        checkOutput("rst_s_tready", 32'(sTready), 32'd0);
    endtask

    // Directed test sequence.
    initial begin
        vecCount  = 0;
        missCount = 0;
        rstN      = 1'b0;
        mTready   = 1'b1;
        bTdata    = '0;
        bTvalid   = '0;
        bTlast    = '0;
        bMtready  = 1'b1;
        sTdata    = '0;
        sTvalid   = '0;
        sTlast    = '0;
        for (int p = 0; p < 4; p++) begin
            srcHead[p] = 0;
            srcTail[p] = 0;
        end
        clearObs();
        @(posedge clk);
        #1;
        resetDut();

        $display("[TB] single requester on port 2");
        clearObs();
        pushByte(2, 8'h41, 1'b0);
        pushByte(2, 8'h42, 1'b0);
        pushByte(2, 8'h43, 1'b1);
        driveInputs();
        checkOutput("t1_ready_idle", 32'(sTready), 32'h0);
        applyStimulus();
        checkOutput("t1_ready_grant", 32'(sTready), 32'h4);
        checkOutput("t1_grant_valid", 32'(grantValid), 32'd1);
        checkOutput("t1_grant_id", 32'(grantId), 32'd2);
        waitOutputs(3, 20);
        expectBeat("t1_beat0", 8'h41, 1'b0, 2'd2);
        expectBeat("t1_beat1", 8'h42, 1'b0, 2'd2);
        expectBeat("t1_beat2", 8'h43, 1'b1, 2'd2);
        checkOutput("t1_back_idle", 32'(grantValid), 32'd0);
        clearObs();
        pushByte(0, 8'h50, 1'b1);
        pushByte(3, 8'h53, 1'b1);
        driveInputs();
        waitOutputs(2, 20);
        expectBeat("t1_rr_first", 8'h53, 1'b1, 2'd3);
        expectBeat("t1_rr_second", 8'h50, 1'b1, 2'd0);

        $display("[TB] round-robin fairness");
        applyStimulus();
        resetDut();
        for (int r = 0; r < 2; r++) begin
            clearObs();
            pushByte(0, 8'h01, 1'b0);
            pushByte(0, 8'h02, 1'b1);
            pushByte(1, 8'h11, 1'b0);
            pushByte(1, 8'h12, 1'b1);
            pushByte(3, 8'h31, 1'b0);
            pushByte(3, 8'h32, 1'b1);
            driveInputs();
            waitOutputs(6, 40);
            expectBeat("t2_p0a", 8'h01, 1'b0, 2'd0);
            expectBeat("t2_p0b", 8'h02, 1'b1, 2'd0);
            expectBeat("t2_p1a", 8'h11, 1'b0, 2'd1);
            expectBeat("t2_p1b", 8'h12, 1'b1, 2'd1);
            expectBeat("t2_p3a", 8'h31, 1'b0, 2'd3);
            expectBeat("t2_p3b", 8'h32, 1'b1, 2'd3);
        end
        checkOutput("t2_log0", 32'(accLog[0]), 32'(-1));
        checkOutput("t2_log1", 32'(accLog[1]), 32'd0);
        checkOutput("t2_log2", 32'(accLog[2]), 32'd0);
        checkOutput("t2_bubble1", 32'(accLog[3]), 32'(-1));
        checkOutput("t2_log4", 32'(accLog[4]), 32'd1);
        checkOutput("t2_log5", 32'(accLog[5]), 32'd1);
        checkOutput("t2_bubble2", 32'(accLog[6]), 32'(-1));
        checkOutput("t2_log7", 32'(accLog[7]), 32'd3);
        checkOutput("t2_log8", 32'(accLog[8]), 32'd3);

        $display("[TB] burst cut at 16 beats");
        clearObs();
        for (int i = 0; i < 40; i++) pushByte(1, 8'(8'h80 + i), 1'b0);
        driveInputs();
        applyStimulus();
        checkOutput("t3_grant_p1", 32'(grantId), 32'd1);
        pushByte(0, 8'hA0, 1'b0);
        pushByte(0, 8'hA1, 1'b1);
        driveInputs();
        waitOutputs(42, 200);
        for (int i = 0; i < 16; i++) expectBeat("t3_burst1", 8'(8'h80 + i), 1'b0, 2'd1);
        expectBeat("t3_p0a", 8'hA0, 1'b0, 2'd0);
        expectBeat("t3_p0b", 8'hA1, 1'b1, 2'd0);
        for (int i = 16; i < 32; i++) expectBeat("t3_burst2", 8'(8'h80 + i), 1'b0, 2'd1);
        for (int i = 32; i < 40; i++) expectBeat("t3_burst3", 8'(8'h80 + i), 1'b0, 2'd1);
        for (int i = 0; i < 10; i++) applyStimulus();
        checkOutput("t3_tail_timeout", 32'(grantValid), 32'd0);

        $display("[TB] output backpressure");
        clearObs();
        pushByte(2, 8'h11, 1'b0);
        pushByte(2, 8'h12, 1'b0);
        pushByte(2, 8'h13, 1'b0);
        pushByte(2, 8'h14, 1'b1);
        driveInputs();
        applyStimulus();
        applyStimulus();
        applyStimulus();
        mTready = 1'b0;
        applyStimulus();
        checkOutput("t4_stall1_data", 32'(mTdata), 32'h12);
        checkOutput("t4_stall1_ready", 32'(sTready), 32'h0);
        applyStimulus();
        checkOutput("t4_stall2_data", 32'(mTdata), 32'h12);
        checkOutput("t4_stall2_grant", 32'(grantValid), 32'd1);
        mTready = 1'b1;
        waitOutputs(4, 20);
        expectBeat("t4_beat0", 8'h11, 1'b0, 2'd2);
        expectBeat("t4_beat1", 8'h12, 1'b0, 2'd2);
        expectBeat("t4_beat2", 8'h13, 1'b0, 2'd2);
        expectBeat("t4_beat3", 8'h14, 1'b1, 2'd2);
        clearObs();
        pushByte(2, 8'h21, 1'b0);
        driveInputs();
        applyStimulus();
        applyStimulus();
        mTready = 1'b0;
        for (int i = 0; i < 12; i++) applyStimulus();
        checkOutput("t4_nostall_timeout", 32'(grantValid), 32'd1);
        checkOutput("t4_held_valid", 32'(mTvalid), 32'd1);
        checkOutput("t4_held_data", 32'(mTdata), 32'h21);
        mTready = 1'b1;
        for (int i = 0; i < 7; i++) applyStimulus();
        checkOutput("t4_idle7_grant", 32'(grantValid), 32'd1);
        applyStimulus();
        checkOutput("t4_idle8_release", 32'(grantValid), 32'd0);
        checkOutput("t4_beat21_seen", 32'(obsCount), 32'd1);

        $display("[TB] idle timeout hands over to port 3");
        clearObs();
        pushByte(0, 8'h61, 1'b0);
        driveInputs();
        applyStimulus();
        pushByte(3, 8'h73, 1'b1);
        driveInputs();
        for (int i = 0; i < 8; i++) applyStimulus();
        checkOutput("t5_before_timeout", 32'(grantId), 32'd0);
        checkOutput("t5_before_timeout_v", 32'(grantValid), 32'd1);
        applyStimulus();
        checkOutput("t5_timeout", 32'(grantValid), 32'd0);
        applyStimulus();
        checkOutput("t5_regrant_v", 32'(grantValid), 32'd1);
        checkOutput("t5_regrant_id", 32'(grantId), 32'd3);
        waitOutputs(2, 20);
        expectBeat("t5_beat_p0", 8'h61, 1'b0, 2'd0);
        expectBeat("t5_beat_p3", 8'h73, 1'b1, 2'd3);

        $display("[TB] reset in the middle of a packet");
        clearObs();
        for (int i = 0; i < 5; i++) pushByte(2, 8'(8'hC1 + i), (i == 4));
        driveInputs();
        applyStimulus();
        applyStimulus();
        rstN    = 1'b0;
        mTready = 1'b0;
        applyStimulus();
        rstN = 1'b1;
        srcHead[2] = srcTail[2];
        driveInputs();
        checkOutput("t6_m_tvalid", 32'(mTvalid), 32'd0);
        checkOutput("t6_s_tready", 32'(sTready), 32'h0);
        checkOutput("t6_grant_valid", 32'(grantValid), 32'd0);
        mTready = 1'b1;
        clearObs();
        pushByte(2, 8'hF2, 1'b1);
        pushByte(0, 8'hE0, 1'b1);
        driveInputs();
        waitOutputs(2, 20);
        expectBeat("t6_first_p0", 8'hE0, 1'b1, 2'd0);
        expectBeat("t6_then_p2", 8'hF2, 1'b1, 2'd2);

        $display("[TB] timeout disabled holds the grant");
        bTdata  = 32'h0000_0099;
        bTvalid = 4'b0001;
        applyStimulus();
        applyStimulus();
        bTvalid = 4'b1000;
        for (int i = 0; i < 30; i++) applyStimulus();
        checkOutput("t7_grant_held", 32'(bGrantValid), 32'd1);
        checkOutput("t7_grant_id", 32'(bGrantId), 32'd0);
        checkOutput("t7_ready_port0", 32'(bTready), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single 8-bit AXI-Stream transmit input of the uart block among NUM_PORTS byte-stream requesters.
- Round-robin arbitration, one packet per grant: a grant ends on tlast, on MAX_BURST bytes, or on an idle timeout.
- A one-entry registered output stage drives the uart transmit stream, so there is no combinational path from the uart back to the requesters.
- Sits in the 10 MHz domain, between the PL/PS-side producers and uart_inst_0's transmit (s_axis_din) port.

Parameters:
- NUM_PORTS, 4, number of requester streams (2..8).
- DATA_WIDTH, 8, byte width; must equal the uart FRAME_WIDTH.
- MAX_BURST, 16, maximum beats per grant when tlast never arrives (1..255).
- IDLE_TIMEOUT, 64, cycles without a granted-port beat before the grant is revoked; 0 disables the timeout.

Ports:
- clk  in  1  system clock (clk_10mhz_int).
- rst_n  in  1  reset, synchronous, active-low.
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  requester data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tlast  in  NUM_PORTS  per-port end of packet.
- s_axis_tready  out  NUM_PORTS  per-port ready.
- m_axis_tdata  out  DATA_WIDTH  to uart s_axis_din_tdata.
- m_axis_tvalid  out  1  to uart s_axis_din_tvalid.
- m_axis_tready  in  1  from uart s_axis_din_tready.
- m_axis_tlast  out  1  registered copy of the source tlast.
- m_axis_tid  out  $clog2(NUM_PORTS)  source port of the current output beat.
- grant_valid  out  1  high while in XFER.
- grant_id  out  $clog2(NUM_PORTS)  currently granted port.

Behaviour:
- Reset (rst_n low at a rising edge): state=IDLE; rr_ptr=NUM_PORTS-1, so port 0 has first priority; beat_cnt=0; idle_cnt=0.
- Outputs under reset: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tid=0, grant_valid=0, grant_id=0, s_axis_tready=0.
- Reset mid-packet aborts the packet and drops any beat held in the output register, with no flush.
- State IDLE:
  - All s_axis_tready=0.
  - If any tvalid is high, pick the first asserted port scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_PORTS.
  - Register the pick into grant_id, clear beat_cnt and idle_cnt, and go to XFER.
  - Otherwise stay in IDLE.
  - There is always exactly one IDLE cycle between consecutive grants.
- State XFER:
  - s_axis_tready[grant_id] = out_ready, where out_ready = !m_axis_tvalid || m_axis_tready. All other readys are 0.
  - An input beat is accepted when tvalid[grant_id] && tready[grant_id]. On acceptance the output register loads tdata, tlast and tid=grant_id, m_axis_tvalid=1, beat_cnt increments, and idle_cnt clears.
  - Release condition: an accepted beat with tlast=1, or an accepted beat that makes beat_cnt==MAX_BURST. On release, go to IDLE and set rr_ptr=grant_id.
  - If no beat is accepted while tvalid[grant_id]=0, idle_cnt increments. When IDLE_TIMEOUT!=0 and idle_cnt reaches IDLE_TIMEOUT-1 with still no beat, release the grant the same way.
  - Backpressure (out_ready=0) never advances idle_cnt.
- Output register:
  - Clears m_axis_tvalid when m_axis_tready=1 and no new beat loads in the same cycle.
  - Load and unload in the same cycle is allowed, giving full throughput of 1 beat/cycle.
  - Output tdata, tlast and tid are held stable while tvalid=1 and tready=0.
  - The output register may still hold the previous grant's last beat while the arbiter is in IDLE or has re-granted; ordering is preserved.
- Latency: request to first tready is 1 cycle (the IDLE cycle). Accepted beat to m_axis_tvalid is 1 cycle.
- Simultaneous events:
  - tlast on the MAX_BURST-th beat gives a single release, not a double release.
  - A timeout and an accepted beat in the same cycle: the beat wins and idle_cnt clears.
- A burst cut at MAX_BURST does not synthesise an m_axis_tlast; the remainder of that packet is sent on a later grant.
- grant_valid = (state==XFER).

Test Plan:
- Single requester: port 2 sends 3 bytes 0x41,0x42,0x43 with tlast on 0x43; m_tready=1 → tready[2] rises 1 cycle after tvalid; output 0x41,0x42,0x43 with tid=2 and tlast on the 3rd beat; back to IDLE with rr_ptr=2.
- Round-robin fairness: ports 0,1,3 hold 2-byte packets pending simultaneously after reset → output order is port 0, then 1, then 3. Re-arm all three → order is 0,1,3 again, with exactly one bubble cycle on the input side between packets.
- Burst cut: port 1 streams 40 bytes, no tlast, MAX_BURST=16, port 0 also pending → 16 bytes from port 1, then port 0's packet, then port 1 resumes (16, then 8); m_axis_tlast stays 0 on the cut boundaries.
- Backpressure: m_tready toggles 1-0-0-1 during a 4-byte packet → no beat lost or duplicated, m_tdata stable while stalled, idle_cnt does not advance, no timeout.
- Idle timeout: IDLE_TIMEOUT=8; port 0 sends 1 byte without tlast, then drops tvalid; port 3 is pending → grant released after 8 idle cycles, port 3 granted next; IDLE_TIMEOUT=0 variant holds the grant indefinitely.
- Reset mid-packet: assert rst_n=0 for 1 cycle during the 2nd beat of a 5-byte packet → next cycle m_axis_tvalid=0, all tready=0, grant_valid=0; after release port 0 is granted first.
